// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants and the region state shared by the horizontal and vertical timing FSMs.
// Positions are 10-bit; region boundaries are "first index of the region".
package vga_timing_pkg;

  localparam logic [9:0] H_ACTIVE      = 10'd640;
  localparam logic [9:0] HS_PULSE      = 10'd96;
  localparam logic [9:0] H_BACK_PORCH  = 10'd48;
  localparam logic [9:0] H_FRONT_PORCH = 10'd16;
  localparam logic [9:0] H_LINE        = HS_PULSE + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;

  localparam logic [9:0] V_ACTIVE      = 10'd480;
  localparam logic [9:0] VS_PULSE      = 10'd2;
  localparam logic [9:0] V_BACK_PORCH  = 10'd33;
  localparam logic [9:0] V_FRONT_PORCH = 10'd10;
  localparam logic [9:0] V_FRAME       = VS_PULSE + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;

  localparam logic [9:0] H_ACT_START = HS_PULSE + H_BACK_PORCH;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam logic [9:0] H_LAST      = H_LINE - 10'd1;

  localparam logic [9:0] V_ACT_START = VS_PULSE + V_BACK_PORCH;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_ACTIVE;
  localparam logic [9:0] V_LAST      = V_FRAME - 10'd1;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    ACTIVE      = 2'd2,
    FRONT_PORCH = 2'd3
  } region_e;

  function automatic logic [9:0] wrap_inc(input logic [9:0] pos, input logic [9:0] last);
    return (pos == last) ? 10'd0 : pos + 10'd1;
  endfunction

  // pos is the index about to be presented; each region is left when pos reaches the next boundary.
  function automatic region_e next_region(input region_e cur, input logic [9:0] pos,
                                          input logic [9:0] bp_start,
                                          input logic [9:0] act_start,
                                          input logic [9:0] fp_start);
    region_e nxt;
    nxt = cur;
    case (cur)
      SYNC:        if (pos == bp_start)  nxt = BACK_PORCH;
      BACK_PORCH:  if (pos == act_start) nxt = ACTIVE;
      ACTIVE:      if (pos == fp_start)  nxt = FRONT_PORCH;
      FRONT_PORCH: if (pos == 10'd0)     nxt = SYNC;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_horiz_fsm.sv
// Horizontal pixel FSM: HSYNC, visible-column address, and a line_start flag that is high
// while pixel 799 is presented so the vertical FSM steps on the 799->0 wrap edge.
module vga_horiz_fsm
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       hs,
  output logic       x_valid,
  output logic [9:0] x,
  output logic       line_start
);

  logic [9:0] h_q, h_d;
  region_e    state_q, state_d;
  logic       hs_q, hs_d;
  logic       x_valid_q, x_valid_d;
  logic [9:0] x_q, x_d;
  logic       line_start_q, line_start_d;

  // h_q is the pixel index the next edge will present.
  always_comb begin
    state_d      = next_region(state_q, h_q, HS_PULSE, H_ACT_START, H_ACT_END);
    h_d          = wrap_inc(h_q, H_LAST);
    hs_d         = (state_d != SYNC);
    x_valid_d    = (state_d == ACTIVE);
    x_d          = x_valid_d ? (h_q - H_ACT_START) : 10'd0;
    line_start_d = (h_q == H_LAST);
  end

  // Pre-start state looks like the last pixel of a previous line, so the first edge opens line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q          <= 10'd0;
      state_q      <= FRONT_PORCH;
      hs_q         <= 1'b1;
      x_valid_q    <= 1'b0;
      x_q          <= 10'd0;
      line_start_q <= 1'b1;
    end else begin
      h_q          <= h_d;
      state_q      <= state_d;
      hs_q         <= hs_d;
      x_valid_q    <= x_valid_d;
      x_q          <= x_d;
      line_start_q <= line_start_d;
    end
  end

  assign hs         = hs_q;
  assign x_valid    = x_valid_q;
  assign x          = x_q;
  assign line_start = line_start_q;

endmodule

// File: rtl/vga_timing_fsm.sv
// 640x480@60 VGA timing generator: horizontal FSM in a sub-module, vertical region FSM here,
// stepping once per line when line_start is high. All outputs registered; never stalls.
module vga_timing_fsm
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       addr_x_valid,
  output logic [9:0] addr_x,
  output logic       addr_y_valid,
  output logic [9:0] addr_y
);

  logic line_start;

  vga_horiz_fsm u_horiz (
    .clk        (clk),
    .rst_n      (reset),
    .hs         (vga_hs),
    .x_valid    (addr_x_valid),
    .x          (addr_x),
    .line_start (line_start)
  );

  logic [9:0] l_q, l_d;
  region_e    vstate_q, vstate_d;
  logic       vs_q, vs_d;
  logic       y_valid_q, y_valid_d;
  logic [9:0] y_q, y_d;

  // l_q is the line index the next line_start edge will present.
  always_comb begin
    l_d       = l_q;
    vstate_d  = vstate_q;
    vs_d      = vs_q;
    y_valid_d = y_valid_q;
    y_d       = y_q;
    if (line_start) begin
      vstate_d  = next_region(vstate_q, l_q, VS_PULSE, V_ACT_START, V_ACT_END);
      l_d       = wrap_inc(l_q, V_LAST);
      vs_d      = (vstate_d != SYNC);
      y_valid_d = (vstate_d == ACTIVE);
      y_d       = y_valid_d ? (l_q - V_ACT_START) : 10'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_q       <= 10'd0;
      vstate_q  <= FRONT_PORCH;
      vs_q      <= 1'b1;
      y_valid_q <= 1'b0;
      y_q       <= 10'd0;
    end else begin
      l_q       <= l_d;
      vstate_q  <= vstate_d;
      vs_q      <= vs_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
    end
  end

  assign vga_vs       = vs_q;
  assign addr_y_valid = y_valid_q;
  assign addr_y       = y_q;

endmodule

// File: tb/tb_vga_timing_fsm.sv
// Bench for vga_timing_fsm: outputs compared every clock against tick arithmetic (h = t mod 800,
// l = t div 800 mod 525), with a randomly placed asynchronous reset mid-run.
module tb_vga_timing_fsm;

  logic       clk;
  logic       reset;
  logic       vga_hs, vga_vs, addr_x_valid, addr_y_valid;
  logic [9:0] addr_x, addr_y;
  logic [23:0] dut_vec;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .addr_x_valid (addr_x_valid),
    .addr_x       (addr_x),
    .addr_y_valid (addr_y_valid),
    .addr_y       (addr_y)
  );

  assign dut_vec = {vga_hs, vga_vs, addr_x_valid, addr_x, addr_y_valid, addr_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0};

  function automatic logic [23:0] model(input int t);
    int h, l;
    logic hs, vs, xv, yv;
    logic [9:0] x, y;
    h  = t % 800;
    l  = (t / 800) % 525;
    hs = !(h < 96);
    vs = !(l < 2);
    xv = (h >= 144) && (h < 784);
    yv = (l >= 35) && (l < 515);
    x  = xv ? 10'(h - 144) : 10'd0;
    y  = yv ? 10'(l - 35) : 10'd0;
    return {hs, vs, xv, x, yv, y};
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s idx=%0d got=%0h exp=%0h", tag, idx, obs, exp);
    end
  endtask

  initial begin
    int t1, hold, hs_low, xv_cnt, vs_low, yv_first;
    hs_low   = 0;
    xv_cnt   = 0;
    vs_low   = 0;
    yv_first = -1;
    t1   = 800 * 36 + int'($urandom_range(0, 3999));
    hold = int'($urandom_range(2, 5));

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 0, {8'd0, dut_vec}, {8'd0, RESET_VEC});
    @(negedge clk) reset = 1'b1;

    for (int t = 0; t < t1; t++) begin
      @(posedge clk);
      #1;
      check("tick_a", t, {8'd0, dut_vec}, {8'd0, model(t)});
      if (t < 800 && !vga_hs) hs_low++;
      if (t < 800 && addr_x_valid) xv_cnt++;
      if (!vga_vs) vs_low++;
      if (yv_first < 0 && addr_y_valid) yv_first = t;
    end
    check("hs_low_width", 0, hs_low, 96);
    check("x_valid_width", 0, xv_cnt, 640);
    check("vs_low_clocks", 0, vs_low, 1600);
    check("y_valid_first_tick", 0, yv_first, 35 * 800);

    // Assert reset between clock edges: outputs must clear without waiting for clk.
    #($urandom_range(1, 7));
    reset = 1'b0;
    #1;
    check("async_reset", t1, {8'd0, dut_vec}, {8'd0, RESET_VEC});
    repeat (hold) @(posedge clk);
    #1;
    check("reset_hold2", hold, {8'd0, dut_vec}, {8'd0, RESET_VEC});
    @(negedge clk) reset = 1'b1;

    for (int t = 0; t < 800 * 37; t++) begin
      @(posedge clk);
      #1;
      check("tick_b", t, {8'd0, dut_vec}, {8'd0, model(t)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
